bu_exec: RTL and testbench

Branch execution unit that sits directly downstream of the branch-unit reservation station. It accepts one in-order branch/jump per cycle from the station's head, along with operand values read from the PRF. It resolves the outcome in a two-stage pipeline and returns three things: the link-register writeback, the ROB completion, and a redirect on mispredict. The frontend predicts every branch not-taken, so any taken branch, JAL, or JALR is a mispredict.

---
 rtl/bu_exec_if.sv | 62 ++++++
 rtl/bu_exec.sv | 184 ++++++++++++++++++
 tb/tb_bu_exec.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bu_exec_if.sv
// ---------------------------------------------------------------------------
// bu_exec_if : bundle between the branch-unit reservation station, the PRF
// operand read, the CDB/ROB writeback and the branch execution unit.
//
// Parameter:
//   ROB_W  ROB index width
//
// Signals (direction given from the execution unit's side, modport slave):
//   out : fu_rdy                                     accept-this-cycle
//   in  : valid_in, opcode, func3, pd, rob_index,    issue from station head
//         pc, imm, rs1_val, rs2_val
//   in  : flush                                      global recovery
//   in  : wb_ready                                   CDB/ROB accepts result
//   out : out_valid, out_pd, out_we, out_data,       result / link writeback
//         out_rob_index, redirect, redirect_pc       completion + redirect
//   out : perf_branches, perf_mispredicts            counters (0 unless
//                                                    BU_PERF_CNT_EN defined)
// modport master is the mirror image, used by the environment.
// ---------------------------------------------------------------------------
interface bu_exec_if #(
    parameter int ROB_W = 4
);
    logic             fu_rdy;
    logic             valid_in;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       pd;
    logic [ROB_W-1:0] rob_index;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic             flush;
    logic             out_valid;
    logic             wb_ready;
    logic [6:0]       out_pd;
    logic             out_we;
    logic [31:0]      out_data;
    logic [ROB_W-1:0] out_rob_index;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      perf_branches;
    logic [31:0]      perf_mispredicts;

    modport slave (
        output fu_rdy,
        input  valid_in, opcode, func3, pd, rob_index, pc, imm, rs1_val, rs2_val,
        input  flush, wb_ready,
        output out_valid, out_pd, out_we, out_data, out_rob_index,
        output redirect, redirect_pc,
        output perf_branches, perf_mispredicts
    );

    modport master (
        input  fu_rdy,
        output valid_in, opcode, func3, pd, rob_index, pc, imm, rs1_val, rs2_val,
        output flush, wb_ready,
        input  out_valid, out_pd, out_we, out_data, out_rob_index,
        input  redirect, redirect_pc,
        input  perf_branches, perf_mispredicts
    );
endinterface

// File: rtl/bu_exec.sv
// ---------------------------------------------------------------------------
// bu_exec : two-stage branch execution unit.
//   E1 latches the issued branch/jump and resolves it combinationally;
//   E2 is the registered output stage presented to the CDB/ROB.
//   The frontend predicts not-taken, so every taken branch, JAL and JALR
//   raises redirect.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    bu_exec_if.slave (issue, operands, flush, writeback, redirect)
//
// Optional feature: define BU_PERF_CNT_EN to add saturating fire/mispredict
// counters on perf_branches / perf_mispredicts; otherwise both read 0.
// ---------------------------------------------------------------------------
module bu_exec #(
    parameter int ROB_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    bu_exec_if.slave bus
);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // E1 stage
    logic             e1_v_q;
    logic [6:0]       e1_opcode_q;
    logic [2:0]       e1_func3_q;
    logic [6:0]       e1_pd_q;
    logic [ROB_W-1:0] e1_rob_q;
    logic [31:0]      e1_pc_q;
    logic [31:0]      e1_imm_q;
    logic [31:0]      e1_rs1_q;
    logic [31:0]      e1_rs2_q;

    // E2 stage (output registers)
    logic             e2_v_q;
    logic [6:0]       e2_pd_q;
    logic             e2_we_q;
    logic [31:0]      e2_data_q;
    logic [ROB_W-1:0] e2_rob_q;
    logic             e2_redir_q;
    logic [31:0]      e2_rpc_q;

    // Resolved E1 results headed for E2
    logic             e2_we_d;
    logic [31:0]      e2_data_d;
    logic             e2_redir_d;
    logic [31:0]      e2_rpc_d;

    logic fire;
    logic advance;
    logic kill_e1;
    logic fu_rdy;
    logic issue;

    assign fire    = e2_v_q && bus.wb_ready;
    assign advance = !e2_v_q || fire;
    // A redirect leaving E2 means everything behind it is on the wrong path.
    assign kill_e1 = fire && e2_redir_q;
    assign fu_rdy  = !bus.flush && !kill_e1 && (!e1_v_q || advance);
    assign issue   = bus.valid_in && fu_rdy;

    assign bus.fu_rdy        = fu_rdy;
    assign bus.out_valid     = e2_v_q;
    assign bus.out_pd        = e2_pd_q;
    assign bus.out_we        = e2_we_q;
    assign bus.out_data      = e2_data_q;
    assign bus.out_rob_index = e2_rob_q;
    assign bus.redirect      = e2_redir_q;
    assign bus.redirect_pc   = e2_rpc_q;

    always_comb begin
        logic        taken;
        logic        is_jump;
        logic [31:0] target;
        logic [31:0] jalr_sum;

        taken    = 1'b0;
        is_jump  = 1'b0;
        jalr_sum = e1_rs1_q + e1_imm_q;
        target   = e1_pc_q + e1_imm_q;
        case (e1_opcode_q)
            OP_BRANCH: begin
                case (e1_func3_q)
                    3'b000:  taken = (e1_rs1_q == e1_rs2_q);
                    3'b001:  taken = (e1_rs1_q != e1_rs2_q);
                    3'b100:  taken = ($signed(e1_rs1_q) <  $signed(e1_rs2_q));
                    3'b101:  taken = ($signed(e1_rs1_q) >= $signed(e1_rs2_q));
                    3'b110:  taken = (e1_rs1_q <  e1_rs2_q);
                    3'b111:  taken = (e1_rs1_q >= e1_rs2_q);
                    default: taken = 1'b0;
                endcase
            end
            OP_JAL: begin
                taken   = 1'b1;
                is_jump = 1'b1;
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_jump = 1'b1;
                target  = {jalr_sum[31:1], 1'b0};
            end
            default: taken = 1'b0;
        endcase
        e2_data_d  = e1_pc_q + 32'd4;
        e2_redir_d = taken;
        e2_rpc_d   = taken ? target : e2_data_d;
        e2_we_d    = is_jump && (e1_pd_q != 7'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e1_v_q      <= 1'b0;
            e1_opcode_q <= '0;
            e1_func3_q  <= '0;
            e1_pd_q     <= '0;
            e1_rob_q    <= '0;
            e1_pc_q     <= '0;
            e1_imm_q    <= '0;
            e1_rs1_q    <= '0;
            e1_rs2_q    <= '0;
            e2_v_q      <= 1'b0;
            e2_pd_q     <= '0;
            e2_we_q     <= 1'b0;
            e2_data_q   <= '0;
            e2_rob_q    <= '0;
            e2_redir_q  <= 1'b0;
            e2_rpc_q    <= '0;
        end else if (bus.flush) begin
            e1_v_q <= 1'b0;
            e2_v_q <= 1'b0;
        end else begin
            if (advance) begin
                e2_v_q <= e1_v_q && !kill_e1;
                if (e1_v_q && !kill_e1) begin
                    e2_pd_q    <= e1_pd_q;
                    e2_we_q    <= e2_we_d;
                    e2_data_q  <= e2_data_d;
                    e2_rob_q   <= e1_rob_q;
                    e2_redir_q <= e2_redir_d;
                    e2_rpc_q   <= e2_rpc_d;
                end
            end
            if (issue) begin
                e1_v_q      <= 1'b1;
                e1_opcode_q <= bus.opcode;
                e1_func3_q  <= bus.func3;
                e1_pd_q     <= bus.pd;
                e1_rob_q    <= bus.rob_index;
                e1_pc_q     <= bus.pc;
                e1_imm_q    <= bus.imm;
                e1_rs1_q    <= bus.rs1_val;
                e1_rs2_q    <= bus.rs2_val;
            end else if (advance) begin
                e1_v_q <= 1'b0;
            end
        end
    end

`ifdef BU_PERF_CNT_EN
    logic [31:0] perf_br_q;
    logic [31:0] perf_mp_q;

    // Counts survive flush; only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_br_q <= '0;
            perf_mp_q <= '0;
        end else if (fire) begin
            if (perf_br_q != 32'hFFFF_FFFF) perf_br_q <= perf_br_q + 32'd1;
            if (e2_redir_q && (perf_mp_q != 32'hFFFF_FFFF)) perf_mp_q <= perf_mp_q + 32'd1;
        end
    end

    assign bus.perf_branches    = perf_br_q;
    assign bus.perf_mispredicts = perf_mp_q;
`else
    assign bus.perf_branches    = 32'd0;
    assign bus.perf_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_bu_exec.sv
// ---------------------------------------------------------------------------
// tb_bu_exec : self-checking bench for bu_exec.
// A directed vector table covers the resolve rules; hand sequences cover
// backpressure, redirect kill, flush, mid-stream reset and the counters;
// a randomized phase runs against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_bu_exec;
    localparam int ROB_W = 4;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bu_exec_if #(.ROB_W(ROB_W)) bif ();

    bu_exec #(.ROB_W(ROB_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct packed {
        logic [6:0]       opcode;
        logic [2:0]       func3;
        logic [6:0]       pd;
        logic [ROB_W-1:0] rob;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [31:0]      rs1;
        logic [31:0]      rs2;
    } instr_t;

    typedef struct packed {
        logic             redirect;
        logic [31:0]      rpc;
        logic             we;
        logic [31:0]      data;
        logic [6:0]       pd;
        logic [ROB_W-1:0] rob;
    } res_t;

    typedef struct packed {
        res_t res;
        logic at_out;   // result is being presented on the output
    } ent_t;

    typedef struct packed {
        instr_t      ins;
        logic        exp_redir;
        logic [31:0] exp_rpc;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    logic [31:0] perf_b_exp = 0;
    logic [31:0] perf_m_exp = 0;
    instr_t idle_ins = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] pd,
                                  input logic [ROB_W-1:0] rob, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
        instr_t r;
        r.opcode = op; r.func3 = f3; r.pd = pd; r.rob = rob;
        r.pc = pc; r.imm = imm; r.rs1 = rs1; r.rs2 = rs2;
        return r;
    endfunction

    // Reference outcome straight from the branch/jump rules.
    function automatic res_t ref_result(input instr_t i);
        res_t r;
        bit taken = 0;
        logic [31:0] tgt = i.pc + i.imm;
        int signed a = i.rs1;
        int signed b = i.rs2;
        if (i.opcode == OP_BR) begin
            if (i.func3 == 3'd0) taken = (i.rs1 == i.rs2);
            if (i.func3 == 3'd1) taken = (i.rs1 != i.rs2);
            if (i.func3 == 3'd4) taken = (a < b);
            if (i.func3 == 3'd5) taken = !(a < b);
            if (i.func3 == 3'd6) taken = (i.rs1 < i.rs2);
            if (i.func3 == 3'd7) taken = !(i.rs1 < i.rs2);
        end else if (i.opcode == OP_JAL) begin
            taken = 1;
        end else if (i.opcode == OP_JALR) begin
            taken = 1;
            tgt = (i.rs1 + i.imm) & 32'hFFFF_FFFE;
        end
        r.redirect = taken;
        r.data = i.pc + 32'd4;
        r.rpc = taken ? tgt : r.data;
        r.we = ((i.opcode == OP_JAL) || (i.opcode == OP_JALR)) && (i.pd != 0);
        r.pd = i.pd;
        r.rob = i.rob;
        return r;
    endfunction

    // One clock of stimulus, with every visible output checked against the model.
    task automatic cyc(input bit v, input instr_t ins, input bit wr, input bit fl);
        int n;
        bit head_out, fire, kill, exp_rdy;
        bif.valid_in  = v;
        bif.opcode    = ins.opcode;
        bif.func3     = ins.func3;
        bif.pd        = ins.pd;
        bif.rob_index = ins.rob;
        bif.pc        = ins.pc;
        bif.imm       = ins.imm;
        bif.rs1_val   = ins.rs1;
        bif.rs2_val   = ins.rs2;
        bif.wb_ready  = wr;
        bif.flush     = fl;
        #1;
        n = q.size();
        head_out = (n > 0) && q[0].at_out;
        fire = head_out && wr;
        kill = fire && q[0].res.redirect;
        exp_rdy = !fl && !kill && ((n < 2) || fire);
        chk("fu_rdy", 32'(bif.fu_rdy), 32'(exp_rdy));
        chk("out_valid", 32'(bif.out_valid), 32'(head_out));
        if (head_out) begin
            chk("redirect", 32'(bif.redirect), 32'(q[0].res.redirect));
            chk("redirect_pc", bif.redirect_pc, q[0].res.rpc);
            chk("out_we", 32'(bif.out_we), 32'(q[0].res.we));
            chk("out_data", bif.out_data, q[0].res.data);
            chk("out_pd", 32'(bif.out_pd), 32'(q[0].res.pd));
            chk("out_rob_index", 32'(bif.out_rob_index), 32'(q[0].res.rob));
        end
        chk("perf_branches", bif.perf_branches, perf_b_exp);
        chk("perf_mispredicts", bif.perf_mispredicts, perf_m_exp);
        @(posedge clk);
        if (fire) begin
            $display("fire rob=%0d redirect=%0b rpc=%h we=%0b data=%h",
                     q[0].res.rob, q[0].res.redirect, q[0].res.rpc, q[0].res.we, q[0].res.data);
`ifdef BU_PERF_CNT_EN
            perf_b_exp++;
            if (kill) perf_m_exp++;
`endif
        end
        if (fl) begin
            q.delete();
        end else begin
            if (fire) void'(q.pop_front());
            if (kill) q.delete();
            if (q.size() > 0) q[0].at_out = 1'b1;
            if (v && exp_rdy) q.push_back('{res: ref_result(ins), at_out: 1'b0});
        end
        #1;
    endtask

    task automatic do_reset();
        bif.valid_in = 1'b0;
        bif.flush = 1'b0;
        bif.wb_ready = 1'b1;
        reset = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst_fu_rdy", 32'(bif.fu_rdy), 32'd1);
        chk("rst_redirect", 32'(bif.redirect), 32'd0);
        chk("rst_out_we", 32'(bif.out_we), 32'd0);
        chk("rst_perf_br", bif.perf_branches, 32'd0);
        chk("rst_perf_mp", bif.perf_mispredicts, 32'd0);
        q.delete();
        perf_b_exp = 0;
        perf_m_exp = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    vec_t vt[13];

    initial begin
        vt[0]  = '{mk(OP_BR,  3'd0, 7'd3, 4'd0,  32'h100, 32'h20, 32'd5, 32'd5), 1'b1, 32'h120, 1'b0, 32'h104};
        vt[1]  = '{mk(OP_BR,  3'd4, 7'd0, 4'd1,  32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1), 1'b1, 32'h210, 1'b0, 32'h204};
        vt[2]  = '{mk(OP_BR,  3'd6, 7'd0, 4'd2,  32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1), 1'b0, 32'h204, 1'b0, 32'h204};
        vt[3]  = '{mk(OP_JALR,3'd0, 7'd9, 4'd3,  32'h40,  32'h0,  32'h1003, 32'd0), 1'b1, 32'h1002, 1'b1, 32'h44};
        vt[4]  = '{mk(OP_JALR,3'd0, 7'd0, 4'd4,  32'h40,  32'h0,  32'h1003, 32'd0), 1'b1, 32'h1002, 1'b0, 32'h44};
        vt[5]  = '{mk(OP_JAL, 3'd0, 7'd1, 4'd5,  32'h1000, 32'hFFFF_FFF8, 32'd0, 32'd0), 1'b1, 32'hFF8, 1'b1, 32'h1004};
        vt[6]  = '{mk(OP_BR,  3'd5, 7'd0, 4'd6,  32'h300, 32'h40, 32'h8000_0000, 32'd0), 1'b0, 32'h304, 1'b0, 32'h304};
        vt[7]  = '{mk(OP_BR,  3'd7, 7'd0, 4'd7,  32'h300, 32'h40, 32'h8000_0000, 32'd0), 1'b1, 32'h340, 1'b0, 32'h304};
        vt[8]  = '{mk(OP_BR,  3'd2, 7'd0, 4'd8,  32'h400, 32'h8,  32'd7, 32'd7), 1'b0, 32'h404, 1'b0, 32'h404};
        vt[9]  = '{mk(OP_ALU, 3'd0, 7'd5, 4'd9,  32'h500, 32'h8,  32'd1, 32'd1), 1'b0, 32'h504, 1'b0, 32'h504};
        vt[10] = '{mk(OP_JAL, 3'd0, 7'd2, 4'd10, 32'hFFFF_FFFC, 32'h8, 32'd0, 32'd0), 1'b1, 32'h4, 1'b1, 32'h0};
        vt[11] = '{mk(OP_BR,  3'd1, 7'd0, 4'd11, 32'h600, 32'hFFFF_FF00, 32'd5, 32'd6), 1'b1, 32'h500, 1'b0, 32'h604};
        vt[12] = '{mk(OP_JALR,3'd0, 7'd4, 4'd12, 32'h700, 32'h11, 32'h2000, 32'd0), 1'b1, 32'h2010, 1'b1, 32'h704};

        do_reset();

        // Directed table: issue, wait two edges, compare, drain.
        for (int i = 0; i < 13; i++) begin
            cyc(1'b1, vt[i].ins, 1'b1, 1'b0);
            cyc(1'b0, idle_ins, 1'b1, 1'b0);
            chk($sformatf("vec%0d_out_valid", i), 32'(bif.out_valid), 32'd1);
            chk($sformatf("vec%0d_redirect", i), 32'(bif.redirect), 32'(vt[i].exp_redir));
            chk($sformatf("vec%0d_redirect_pc", i), bif.redirect_pc, vt[i].exp_rpc);
            chk($sformatf("vec%0d_out_we", i), 32'(bif.out_we), 32'(vt[i].exp_we));
            chk($sformatf("vec%0d_out_data", i), bif.out_data, vt[i].exp_data);
            cyc(1'b0, idle_ins, 1'b1, 1'b0);
        end

        // Backpressure: two accepts, third refused, E2 held, drain in order.
        cyc(1'b1, vt[2].ins, 1'b0, 1'b0);
        cyc(1'b1, vt[6].ins, 1'b0, 1'b0);
        cyc(1'b1, vt[8].ins, 1'b0, 1'b0);
        chk("bp_fu_rdy_low", 32'(bif.fu_rdy), 32'd0);
        chk("bp_head_rob", 32'(bif.out_rob_index), 32'd2);
        cyc(1'b0, idle_ins, 1'b0, 1'b0);
        cyc(1'b0, idle_ins, 1'b0, 1'b0);
        chk("bp_head_still", 32'(bif.out_rob_index), 32'd2);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);
        chk("bp_second_rob", 32'(bif.out_rob_index), 32'd6);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);

        // Taken BNE fires with a younger BEQ in E1: the BEQ must vanish.
        cyc(1'b1, vt[11].ins, 1'b0, 1'b0);
        cyc(1'b1, vt[0].ins, 1'b0, 1'b0);
        cyc(1'b1, vt[2].ins, 1'b1, 1'b0);
        chk("kill_no_younger", 32'(bif.out_valid), 32'd0);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);

        // Flush with both stages occupied.
        cyc(1'b1, vt[2].ins, 1'b0, 1'b0);
        cyc(1'b1, vt[6].ins, 1'b0, 1'b0);
        cyc(1'b0, idle_ins, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(bif.out_valid), 32'd0);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);

        // Counters: 4 fires, 1 mispredict, from a clean reset.
        do_reset();
        cyc(1'b1, vt[2].ins, 1'b1, 1'b0);
        cyc(1'b1, vt[6].ins, 1'b1, 1'b0);
        cyc(1'b1, vt[8].ins, 1'b1, 1'b0);
        cyc(1'b1, vt[0].ins, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, idle_ins, 1'b1, 1'b0);
`ifdef BU_PERF_CNT_EN
        chk("perf_branches_4", bif.perf_branches, 32'd4);
        chk("perf_mispredicts_1", bif.perf_mispredicts, 32'd1);
`else
        chk("perf_branches_off", bif.perf_branches, 32'd0);
        chk("perf_mispredicts_off", bif.perf_mispredicts, 32'd0);
`endif

        // Reset mid-stream: in-flight entries disappear without output.
        cyc(1'b1, vt[3].ins, 1'b1, 1'b0);
        cyc(1'b1, vt[9].ins, 1'b1, 1'b0);
        do_reset();
        cyc(1'b0, idle_ins, 1'b1, 1'b0);
        cyc(1'b0, idle_ins, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            instr_t ri;
            int sel;
            sel = $urandom_range(0, 9);
            ri.func3 = 3'($urandom_range(0, 7));
            if (sel <= 5 || sel == 9) ri.opcode = OP_BR;
            else if (sel == 6) ri.opcode = OP_JAL;
            else if (sel == 7) ri.opcode = OP_JALR;
            else ri.opcode = OP_ALU;
            ri.pd  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
            ri.rob = ROB_W'(c);
            ri.pc  = $urandom;
            ri.imm = $urandom;
            ri.rs1 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            ri.rs2 = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            cyc(($urandom_range(0, 9) < 7), ri, ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 99) < 3));
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, idle_ins, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
